spike_event_arbiter: RTL and testbench

Round-robin scheduler that collects spike events from N neurons and serializes them, one event per handshake, onto a single shared synapse-update port. It sits between the neuron array and the synapse datapath, replacing direct neuron-to-synapse wiring so that one synapse unit can serve every neuron. Events are buffered one deep per neuron, and overruns are flagged.

---
 rtl/snn_pkg.sv | 14 +
 rtl/rr_pick.sv | 33 +++
 rtl/spike_event_arbiter.sv | 150 +++++++++++++++
 tb/tb_spike_event_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network event schedulers.
// Contents:
//   arb_state_t        - arbiter FSM state (ARB_IDLE, ARB_OFFER)
//   N_NEURONS_DEFAULT  - default number of spike sources per arbiter
package snn_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OFFER = 1'b1
    } arb_state_t;

    localparam int unsigned N_NEURONS_DEFAULT = 4;

endpackage : snn_pkg

// File: rtl/rr_pick.sv
// Combinational rotate-priority finder.
// Scans req starting at index ptr, wrapping from N-1 back to 0, and returns
// the first set index.
// Ports:
//   req    in  [N-1:0]     request vector
//   ptr    in  [ID_W-1:0]  index with highest priority this cycle
//   gnt_id out [ID_W-1:0]  first set index at or after ptr (0 if none)
//   any    out             at least one request bit is set
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] gnt_id,
    output logic            any
);

    always_comb begin : pick
        int unsigned idx;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any    = 1'b1;
                gnt_id = idx[ID_W-1:0];
            end
        end
    end

endmodule : rr_pick

// File: rtl/spike_event_arbiter.sv
// Round-robin spike event arbiter.
// Collects one-deep pending spike events from N_NEURONS sources and offers
// them one at a time on a valid/ready port to a shared synapse unit.
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   ena        in   enable; low suppresses capture and new offers
//   spike_in   in   per-neuron spike, one event per high cycle
//   ev_valid   out  event offered (registered)
//   ev_id      out  id of offered neuron (registered)
//   ev_ready   in   synapse unit accepts the offered event
//   busy       out  any event pending or offered
//   overflow   out  sticky flag: an event was dropped (registered)
//   clear_ovf  in   clears overflow; a same-cycle new overflow wins
module spike_event_arbiter
    import snn_pkg::*;
#(
    parameter int unsigned N_NEURONS = N_NEURONS_DEFAULT,
    parameter int unsigned ID_W      = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [N_NEURONS-1:0] spike_in,
    output logic                 ev_valid,
    output logic [ID_W-1:0]      ev_id,
    input  logic                 ev_ready,
    output logic                 busy,
    output logic                 overflow,
    input  logic                 clear_ovf
);

    localparam logic [N_NEURONS-1:0] ONE_HOT0 = {{(N_NEURONS-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0]      LAST_ID  = ID_W'(N_NEURONS - 1);

    arb_state_t           state_q, state_d;
    logic [N_NEURONS-1:0] pending_q, pending_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic                 ev_valid_q, ev_valid_d;
    logic [ID_W-1:0]      ev_id_q, ev_id_d;
    logic                 overflow_q, overflow_d;

    logic                 hs;
    logic [N_NEURONS-1:0] clr_mask;
    logic [N_NEURONS-1:0] cap;
    logic [N_NEURONS-1:0] pend_after_hs;
    logic                 ovf_hit;
    logic [ID_W-1:0]      ptr_after;
    logic [N_NEURONS-1:0] pick_req;
    logic [ID_W-1:0]      pick_ptr;
    logic [ID_W-1:0]      pick_id;
    logic                 pick_any;

    // Pending bookkeeping and overflow detection.
    always_comb begin
        hs            = ev_valid_q & ev_ready;
        clr_mask      = hs ? (ONE_HOT0 << ev_id_q) : '0;
        cap           = ena ? spike_in : '0;
        pend_after_hs = pending_q & ~clr_mask;
        pending_d     = pend_after_hs | cap;
        // A spike on the id being handshaked refills a just-freed slot,
        // so it is compared against the post-handshake view.
        ovf_hit       = |(cap & pend_after_hs);
        if (ovf_hit) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        ptr_after = (ev_id_q == LAST_ID) ? '0 : ev_id_q + ID_W'(1);
    end

    // One finder serves both cases: from ptr in IDLE, and from the
    // post-handshake pointer over the remaining bits in OFFER.
    always_comb begin
        if (state_q == ARB_OFFER) begin
            pick_req = pend_after_hs;
            pick_ptr = ptr_after;
        end else begin
            pick_req = pending_q;
            pick_ptr = ptr_q;
        end
    end

    rr_pick #(
        .N    (N_NEURONS),
        .ID_W (ID_W)
    ) u_pick (
        .req    (pick_req),
        .ptr    (pick_ptr),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        ev_valid_d = ev_valid_q;
        ev_id_d    = ev_id_q;
        ptr_d      = ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (ena && pick_any) begin
                    state_d    = ARB_OFFER;
                    ev_valid_d = 1'b1;
                    ev_id_d    = pick_id;
                end
            end
            ARB_OFFER: begin
                if (hs) begin
                    ptr_d = ptr_after;
                    if (ena && pick_any) begin
                        ev_id_d = pick_id;
                    end else begin
                        state_d    = ARB_IDLE;
                        ev_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d    = ARB_IDLE;
                ev_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            pending_q  <= '0;
            ptr_q      <= '0;
            ev_valid_q <= 1'b0;
            ev_id_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            ptr_q      <= ptr_d;
            ev_valid_q <= ev_valid_d;
            ev_id_q    <= ev_id_d;
            overflow_q <= overflow_d;
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_id    = ev_id_q;
    assign overflow = overflow_q;
    assign busy     = (|pending_q) | ev_valid_q;

endmodule : spike_event_arbiter

// File: tb/tb_spike_event_arbiter.sv
module tb_spike_event_arbiter;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic [N-1:0] spike_in;
    logic         ev_valid;
    logic [1:0]   ev_id;
    logic         ev_ready;
    logic         busy;
    logic         overflow;
    logic         clear_ovf;

    int checks;
    int errors;
    bit started;

    spike_event_arbiter #(.N_NEURONS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .spike_in  (spike_in),
        .ev_valid  (ev_valid),
        .ev_id     (ev_id),
        .ev_ready  (ev_ready),
        .busy      (busy),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference ----------------
    bit m_pend [N];
    int m_ptr;
    bit m_valid;
    int m_id;
    bit m_ovf;

    initial begin
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_ptr = 0; m_valid = 1'b0; m_id = 0; m_ovf = 1'b0;
    end

    function automatic int rr_search(bit req [N], int start);
        for (int k = 0; k < N; k++) begin
            if (req[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        bit np [N];
        int nptr, nid, sel;
        bit nvalid, novf, hs, ovf_set;
        started <= 1'b1;
        np = m_pend; nptr = m_ptr; nvalid = m_valid; nid = m_id; novf = m_ovf;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) np[i] = 1'b0;
            nptr = 0; nvalid = 1'b0; nid = 0; novf = 1'b0;
        end else begin
            hs = m_valid && ev_ready;
            if (hs) begin
                np[m_id] = 1'b0;
                nptr = (m_id + 1) % N;
            end
            // np now holds the registered view minus the accepted event
            sel = -1;
            if (!m_valid || hs) sel = ena ? rr_search(np, hs ? nptr : m_ptr) : -1;
            ovf_set = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (ena && spike_in[i]) begin
                    if (np[i]) ovf_set = 1'b1;
                    np[i] = 1'b1;
                end
            end
            novf = ovf_set ? 1'b1 : (clear_ovf ? 1'b0 : m_ovf);
            if (!m_valid || hs) begin
                if (sel >= 0) begin
                    nvalid = 1'b1; nid = sel;
                end else begin
                    nvalid = 1'b0;
                end
            end
        end
        m_pend  <= np;
        m_ptr   <= nptr;
        m_valid <= nvalid;
        m_id    <= nid;
        m_ovf   <= novf;
    end

    function automatic bit model_busy();
        bit b;
        b = m_valid;
        for (int i = 0; i < N; i++) b |= m_pend[i];
        return b;
    endfunction

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (ev_valid !== m_valid) begin
                errors++;
                $display("FAIL ev_valid t=%0t got=%b exp=%b", $time, ev_valid, m_valid);
            end
            checks++;
            if (busy !== model_busy()) begin
                errors++;
                $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, model_busy());
            end
            checks++;
            if (overflow !== m_ovf) begin
                errors++;
                $display("FAIL overflow t=%0t got=%b exp=%b", $time, overflow, m_ovf);
            end
            if (m_valid) begin
                checks++;
                if (ev_id !== 2'(m_id)) begin
                    errors++;
                    $display("FAIL ev_id t=%0t got=%0d exp=%0d", $time, ev_id, m_id);
                end
            end
        end
    end

    // ---------------- directed literal expectations ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; ena = 1'b1; spike_in = '0; ev_ready = 1'b0; clear_ovf = 1'b0;

        // Reset / idle
        do_reset(2);
        lit("rst_valid", 8'(ev_valid), 8'd0);
        lit("rst_id", 8'(ev_id), 8'd0);
        lit("rst_busy", 8'(busy), 8'd0);
        lit("rst_ovf", 8'(overflow), 8'd0);
        tick();
        lit("idle_valid", 8'(ev_valid), 8'd0);

        // Single event: spike in cycle t, offer visible after t+2 edge
        ev_ready = 1'b1;
        spike_in = 4'b0100; tick(); spike_in = '0;
        lit("single_t1_valid", 8'(ev_valid), 8'd0);
        lit("single_t1_busy", 8'(busy), 8'd1);
        tick();
        lit("single_valid", 8'(ev_valid), 8'd1);
        lit("single_id", 8'(ev_id), 8'd2);
        tick();
        lit("single_done_valid", 8'(ev_valid), 8'd0);
        lit("single_done_busy", 8'(busy), 8'd0);

        // Round-robin fairness from a fresh pointer
        do_reset(1);
        spike_in = 4'b1111; tick(); spike_in = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            lit("rr_valid", 8'(ev_valid), 8'd1);
            lit("rr_id", 8'(ev_id), 8'(i));
        end
        tick();
        lit("rr_end_valid", 8'(ev_valid), 8'd0);
        spike_in = 4'b1001; tick(); spike_in = '0;
        tick();
        lit("rr2_id0", 8'(ev_id), 8'd0);
        tick();
        lit("rr2_id3", 8'(ev_id), 8'd3);
        tick();
        lit("rr2_end", 8'(ev_valid), 8'd0);

        // Backpressure with ena dropped mid-offer
        do_reset(1);
        ev_ready = 1'b0;
        spike_in = 4'b0010; tick(); spike_in = '0;
        tick();
        lit("bp_offer_id", 8'(ev_id), 8'd1);
        spike_in = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            tick();
            spike_in = '0;
            if (i == 1) ena = 1'b0;
            lit("bp_hold_valid", 8'(ev_valid), 8'd1);
            lit("bp_hold_id", 8'(ev_id), 8'd1);
        end
        ev_ready = 1'b1; tick();
        lit("bp_ena0_valid", 8'(ev_valid), 8'd0);
        lit("bp_ena0_busy", 8'(busy), 8'd1);
        ena = 1'b1; tick();
        lit("bp_next_valid", 8'(ev_valid), 8'd1);
        lit("bp_next_id", 8'(ev_id), 8'd3);
        tick();
        lit("bp_done_busy", 8'(busy), 8'd0);

        // Overflow, clear, and refill in handshake cycle
        do_reset(1);
        ev_ready = 1'b0;
        spike_in = 4'b0001; tick();
        lit("ovf_first", 8'(overflow), 8'd0);
        tick(); tick(); spike_in = '0;
        lit("ovf_set", 8'(overflow), 8'd1);
        clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
        lit("ovf_cleared", 8'(overflow), 8'd0);
        ev_ready = 1'b1; spike_in = 4'b0001; tick(); spike_in = '0;
        lit("refill_ovf", 8'(overflow), 8'd0);
        lit("refill_busy", 8'(busy), 8'd1);
        tick();
        lit("refill_valid", 8'(ev_valid), 8'd1);
        lit("refill_id", 8'(ev_id), 8'd0);
        tick();
        lit("refill_done", 8'(busy), 8'd0);

        // Reset in the middle of an offer
        do_reset(1);
        ev_ready = 1'b0;
        spike_in = 4'b0110; tick(); spike_in = '0;
        tick();
        lit("midrst_offer", 8'(ev_valid), 8'd1);
        do_reset(1);
        lit("midrst_valid", 8'(ev_valid), 8'd0);
        lit("midrst_busy", 8'(busy), 8'd0);
        ev_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            lit("midrst_stale", 8'(ev_valid), 8'd0);
        end

        // Randomized traffic, checked cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            spike_in  = 4'($urandom) & 4'($urandom) & 4'($urandom);
            ena       = ($urandom_range(0, 9) != 0);
            ev_ready  = ($urandom_range(0, 2) != 0);
            clear_ovf = ($urandom_range(0, 15) == 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n = 1'b1; spike_in = '0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_spike_event_arbiter
